// File: rtl/shift_pipe_unit.sv
// rtl/shift_pipe_unit.sv - pipelined barrel shifter/rotator, one stage per shift level, valid/ready handshake
module shift_pipe_unit #(
  parameter  int WIDTH = 16,
  parameter  int TAG_W = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_count,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  logic [CNT_W-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] sign_q, sign_d;
  logic [WIDTH-1:0] data_q [CNT_W];
  logic [WIDTH-1:0] data_d [CNT_W];
  logic [CNT_W-1:0] cnt_q  [CNT_W];
  logic [CNT_W-1:0] cnt_d  [CNT_W];
  logic [2:0]       op_q   [CNT_W];
  logic [2:0]       op_d   [CNT_W];
  logic [TAG_W-1:0] tag_q  [CNT_W];
  logic [TAG_W-1:0] tag_d  [CNT_W];
  logic [CNT_W-1:0] adv;

  // One shift level of n bits; sgn is the operand MSB latched at capture, used as SRA fill.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d, input logic [2:0] op,
                                                   input logic sgn, input int n);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    ones = '1;
    case (op)
      OP_ROL:  r = (d << n) | (d >> (WIDTH - n));
      OP_SLL:  r = d << n;
      OP_ROR:  r = (d >> n) | (d << (WIDTH - n));
      OP_SRL:  r = d >> n;
      OP_SRA:  r = (d >> n) | (sgn ? ~(ones >> n) : '0);
      default: r = d;
    endcase
    return r;
  endfunction

  // Advance chain from the output back to s0: a stage moves when empty or when its successor moves.
  always_comb begin
    adv = '0;
    adv[CNT_W-1] = out_ready || !valid_q[CNT_W-1];
    for (int k = CNT_W - 2; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[CNT_W-1];
  assign out_data  = data_q[CNT_W-1];
  assign out_tag   = tag_q[CNT_W-1];

  // Next state per stage: load the predecessor (inputs for s0) with level 2^k applied, else hold.
  always_comb begin
    logic             s_valid;
    logic             s_sign;
    logic [WIDTH-1:0] s_data;
    logic [CNT_W-1:0] s_cnt;
    logic [2:0]       s_op;
    logic [TAG_W-1:0] s_tag;
    valid_d = valid_q;
    sign_d  = sign_q;
    for (int k = 0; k < CNT_W; k++) begin
      data_d[k] = data_q[k];
      cnt_d[k]  = cnt_q[k];
      op_d[k]   = op_q[k];
      tag_d[k]  = tag_q[k];
    end
    s_valid = in_valid;
    s_sign  = in_data[WIDTH-1];
    s_data  = in_data;
    s_cnt   = (in_op > OP_SRA) ? '0 : in_count;
    s_op    = in_op;
    s_tag   = in_tag;
    for (int k = 0; k < CNT_W; k++) begin
      if (adv[k]) begin
        valid_d[k] = s_valid;
        sign_d[k]  = s_sign;
        data_d[k]  = s_cnt[k] ? shift_level(s_data, s_op, s_sign, 1 << k) : s_data;
        cnt_d[k]   = s_cnt;
        op_d[k]    = s_op;
        tag_d[k]   = s_tag;
      end
      s_valid = valid_q[k];
      s_sign  = sign_q[k];
      s_data  = data_q[k];
      s_cnt   = cnt_q[k];
      s_op    = op_q[k];
      s_tag   = tag_q[k];
    end
  end

  // Stage registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      sign_q  <= '0;
      for (int k = 0; k < CNT_W; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
        op_q[k]   <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      sign_q  <= sign_d;
      for (int k = 0; k < CNT_W; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
        op_q[k]   <= op_d[k];
        tag_q[k]  <= tag_d[k];
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe_unit.sv
// tb/tb_shift_pipe_unit.sv - self-checking bench for shift_pipe_unit
module tb_shift_pipe_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_count = '0;
  logic [2:0]  in_op = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  out_tag;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  shift_pipe_unit #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_count(in_count),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Reference: result defined bit-by-bit / arithmetically from the op semantics.
  function automatic logic [15:0] ref_result(input logic [15:0] d, input logic [3:0] c, input logic [2:0] op);
    logic [15:0] r;
    logic [31:0] wide;
    r = '0;
    case (op)
      3'd0: for (int i = 0; i < 16; i++) r[(i + int'(c)) % 16] = d[i];
      3'd1: begin wide = 32'(d) * (32'd1 << c); r = wide[15:0]; end
      3'd2: for (int i = 0; i < 16; i++) r[i] = d[(i + int'(c)) % 16];
      3'd3: r = d / (16'd1 << c);
      3'd4: r = 16'($signed(d) >>> c);
      default: r = d;
    endcase
    return r;
  endfunction

  // Drive one cycle of inputs at the falling edge and report what the next rising edge will transfer.
  task automatic drive_cycle(input logic iv, input logic [15:0] d, input logic [3:0] c, input logic [2:0] op,
                             input logic [3:0] tg, input logic ordy, output logic in_fire,
                             output logic out_fire, output logic [15:0] od, output logic [3:0] ot);
    @(negedge clk);
    in_valid = iv; in_data = d; in_count = c; in_op = op; in_tag = tg; out_ready = ordy;
    #1;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    od = out_data;
    ot = out_tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] vd [8] = '{16'h8001, 16'h8001, 16'h0001, 16'hF000, 16'hF000, 16'h7000, 16'hABCD, 16'h1234};
    logic [3:0]  vc [8] = '{4'd1, 4'd1, 4'd15, 4'd4, 4'd4, 4'd4, 4'd7, 4'd0};
    logic [2:0]  vo [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd0};
    logic [15:0] ve [8] = '{16'h0003, 16'h0002, 16'h0002, 16'h0F00, 16'hFF00, 16'h0700, 16'hABCD, 16'h1234};
    logic [3:0]  vt [8] = '{4'd3, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    logic inf, outf;
    logic [15:0] od;
    logic [3:0] ot;
    for (int v = 0; v < 8; v++) begin
      int lat;
      lat = -1;
      drive_cycle(1'b1, vd[v], vc[v], vo[v], vt[v], 1'b1, inf, outf, od, ot);
      for (int t = 1; t <= 20 && lat < 0; t++) begin
        drive_cycle(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b1, inf, outf, od, ot);
        if (outf) lat = t;
      end
      checks++; if (lat != 4) begin errors++; $display("FAIL dir%0d_latency got %0d want 4", v, lat); end
      checks++; if (od !== ve[v]) begin errors++; $display("FAIL dir%0d_data got %h want %h", v, od, ve[v]); end
      checks++; if (ot !== vt[v]) begin errors++; $display("FAIL dir%0d_tag got %h want %h", v, ot, vt[v]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d [8];
    logic [3:0]  c [8];
    logic [2:0]  o [8];
    int sent, got, first, last, done_t;
    logic inf, outf;
    logic [15:0] od;
    logic [3:0] ot;
    sent = 0; got = 0; first = -1; last = -1; done_t = -1;
    for (int i = 0; i < 8; i++) begin
      d[i] = 16'($urandom); c[i] = 4'($urandom); o[i] = 3'($urandom_range(0, 4));
    end
    for (int t = 0; t < 30; t++) begin
      if (sent < 8) drive_cycle(1'b1, d[sent], c[sent], o[sent], 4'(sent), 1'b1, inf, outf, od, ot);
      else drive_cycle(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b1, inf, outf, od, ot);
      if (inf) begin sent++; if (sent == 8) done_t = t; end
      if (outf && got < 8) begin
        if (first < 0) first = t;
        last = t;
        checks++;
        if (od !== ref_result(d[got], c[got], o[got]) || ot !== 4'(got)) begin
          errors++;
          $display("FAIL b2b_result%0d got %h/%h want %h/%h", got, od, ot, ref_result(d[got], c[got], o[got]), 4'(got));
        end
        got++;
      end
    end
    checks++; if (done_t != 7) begin errors++; $display("FAIL b2b_accept_rate got last accept t=%0d want 7", done_t); end
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", got); end
    checks++; if (last - first != 7) begin errors++; $display("FAIL b2b_consecutive got span %0d want 7", last - first); end
  endtask

  task automatic test_backpressure();
    int sent, got, stall_acc;
    logic have_stall;
    logic [15:0] stall_d;
    logic [15:0] d [12];
    logic [3:0]  c [12];
    logic [2:0]  o [12];
    logic inf, outf;
    logic [15:0] od;
    logic [3:0] ot;
    sent = 0; got = 0; stall_acc = 0; have_stall = 1'b0; stall_d = '0;
    for (int i = 0; i < 12; i++) begin
      d[i] = 16'($urandom); c[i] = 4'($urandom); o[i] = 3'($urandom_range(0, 7));
    end
    for (int t = 0; t < 60; t++) begin
      if (sent < 12) drive_cycle(1'b1, d[sent], c[sent], o[sent], 4'(sent), t >= 6, inf, outf, od, ot);
      else drive_cycle(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b1, inf, outf, od, ot);
      if (t <= 6 && out_valid) begin
        if (!have_stall) begin have_stall = 1'b1; stall_d = od; end
        else begin
          checks++;
          if (od !== stall_d) begin errors++; $display("FAIL bp_stable t=%0d got %h want %h", t, od, stall_d); end
        end
      end
      if (inf) begin
        if (t < 6) stall_acc++;
        exp_q.push_back({4'(sent), ref_result(d[sent], c[sent], o[sent])});
        sent++;
      end
      if (outf) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra got %h/%h want none", od, ot); end
        else begin
          if ({ot, od} !== exp_q[0]) begin
            errors++; $display("FAIL bp_result%0d got %h/%h want %h/%h", got, ot, od, exp_q[0][19:16], exp_q[0][15:0]);
          end
          void'(exp_q.pop_front());
        end
        got++;
      end
    end
    checks++; if (stall_acc != 4) begin errors++; $display("FAIL bp_accepts got %0d want 4", stall_acc); end
    checks++; if (got != 12 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_count got %0d outputs (%0d left) want 12 (0 left)", got, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic pend;
    logic [15:0] d;
    logic [3:0] c, tg;
    logic [2:0] o;
    logic inf, outf;
    logic [15:0] od;
    logic [3:0] ot;
    int bad;
    pend = 1'b0; d = '0; c = '0; o = '0; tg = '0; bad = 0;
    for (int t = 0; t < 400; t++) begin
      if (!pend && t < 360 && $urandom_range(0, 3) != 0) begin
        pend = 1'b1; d = 16'($urandom); c = 4'($urandom); o = 3'($urandom); tg = 4'($urandom);
      end
      drive_cycle(pend, d, c, o, tg, (t >= 360) || ($urandom_range(0, 2) != 0), inf, outf, od, ot);
      if (inf) begin exp_q.push_back({tg, ref_result(d, c, o)}); pend = 1'b0; end
      if (outf) begin
        checks++;
        if (exp_q.size() == 0 || {ot, od} !== exp_q[0]) begin
          errors++; bad++;
          if (bad < 5) $display("FAIL rand_result t=%0d got %h/%h want %h", t, ot, od, (exp_q.size() != 0) ? exp_q[0] : 20'h0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain got %0d left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    logic inf, outf;
    logic [15:0] od;
    logic [3:0] ot;
    int seen, lat;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 16'h1111 * 16'(i + 1), 4'd2, 3'd0, 4'(i + 1), 1'b0, inf, outf, od, ot);
    for (int t = 0; t < 10 && !out_valid; t++) drive_cycle(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b0, inf, outf, od, ot);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill got out_valid %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL mid_async_data got %h want 0000", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      drive_cycle(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b1, inf, outf, od, ot);
      if (outf) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_empty got %0d outputs want 0", seen); end
    lat = -1;
    drive_cycle(1'b1, 16'h8001, 4'd1, 3'd0, 4'd3, 1'b1, inf, outf, od, ot);
    for (int t = 1; t <= 20 && lat < 0; t++) begin
      drive_cycle(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b1, inf, outf, od, ot);
      if (outf) lat = t;
    end
    checks++; if (lat != 4 || od !== 16'h0003 || ot !== 4'd3) begin
      errors++; $display("FAIL mid_after_reset got lat %0d %h/%h want 4 0003/3", lat, od, ot);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1);
  end
endmodule
